store_queue_p: RTL and testbench
================================

# store_queue_p

Parametrised second-generation store queue for the Jellycore two-way out-of-order core. It allocates up to two stores per cycle in program order and captures address and data from the execute stage by SQ index. Each load gets a youngest-older-store forwarding lookup. Committed stores drain to the data cache through a valid/ready handshake, and speculative (uncommitted) entries are discarded on a pipeline flush. It sits between dispatch/rename, the AGU writeback path, the ROB commit port and the D-cache write port.

## Interface
- SQ_DEPTH, 8: entries; power of two, 4..64
- ADDR_W, 32: word address width
- DATA_W, 32: store data width
- ROB_W, 6: ROB index width
- PTR_W, $clog2(SQ_DEPTH): index width (derived, not overridable)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- disp_valid  in  2  bit0 = older way, bit1 = younger way; either/both
- disp_rob_idx0, disp_rob_idx1  in  ROB_W  ROB index per way
- disp_ready  out  1  high when ≥2 free entries; dispatch is all-or-nothing
- disp_sq_pos0, disp_sq_pos1  out  PTR_W+1  allocated position (index + wrap bit), combinational from tail
- ex_valid  in  1  address/data writeback
- ex_sq_pos  in  PTR_W+1  target entry
- ex_addr  in  ADDR_W; ex_data  in  DATA_W
- commit_valid  in  2  commit oldest 1 (2'b01) or 2 (2'b11) stores; 2'b10 illegal
- flush  in  1  discard all uncommitted entries
- ld_valid  in  1  forwarding lookup
- ld_addr  in  ADDR_W
- ld_sq_pos  in  PTR_W+1  tail snapshot taken at load dispatch; entries before it are older
- ld_fwd_hit  out  1; ld_fwd_data  out  DATA_W; ld_fwd_stall  out  1
- mem_req_valid  out  1; mem_req_addr  out  ADDR_W; mem_req_data  out  DATA_W
- mem_req_ready  in  1
- sq_count  out  PTR_W+1  occupied entries; sq_empty  out  1

## Operation
- Three pointers, each PTR_W+1 bits with a wrap bit: head (oldest), cmt (first uncommitted), tail (next free). Invariant: head ≤ cmt ≤ tail in circular order.
- Occupancy: count = tail − head (mod 2^(PTR_W+1)). Full when count == SQ_DEPTH.
- Per-entry state: valid, addr_ok, committed, rob_idx, addr, data.
- Dispatch (disp_ready high): way0 takes tail, way1 takes tail+1 if way0 is also valid, else tail. Entries are written valid=1, addr_ok=0. Tail advances by popcount(disp_valid).
- Writeback: on ex_valid, if the entry is valid and uncommitted, write addr/data and set addr_ok. Writes to invalid entries are ignored.
- Commit: marks entries cmt and cmt+1 as committed and advances cmt. Committing an entry with addr_ok=0 is a protocol error; the bench asserts on it.
- Drain: mem_req_valid = valid[head] & committed[head]; addr and data come from the head entry. On valid&ready, clear the entry and advance head by 1.
- Flush: tail ← cmt (after same-cycle commit); entries in [cmt, tail) are cleared. Committed entries and the drain are unaffected.
- Forwarding scans the older set [head, ld_sq_pos):
  - ld_fwd_hit when the youngest older entry with addr_ok and addr == ld_addr exists; ld_fwd_data is that entry's data.
  - ld_fwd_stall when any older entry younger than the match (or any older entry, if no match) has addr_ok=0.
  - hit and stall are never both high.
  - All fwd outputs are 0 when ld_valid is low.
- Reset values: all entries invalid, pointers 0, disp_ready=1, sq_empty=1, sq_count=0, mem_req_valid=0, ld_fwd_*=0.

## Timing
- Dispatch, writeback, commit, drain and flush update registers on posedge. Effects are visible the next cycle.
- disp_ready, disp_sq_pos*, mem_req_* and ld_fwd_* are combinational from registered state plus same-cycle inputs. There is no bypass of same-cycle writeback into forwarding.
- Same-cycle priority: flush > dispatch (dispatch dropped); commit is applied before flush; writeback to an entry being flushed is dropped; drain proceeds alongside all others.
- Freed slots from drain count toward disp_ready only from the next cycle.
- Wrap: index = pos[PTR_W−1:0]. The wrap bit distinguishes full from empty.
- reset is asynchronous mid-operation: all state clears immediately, and any in-flight mem_req is abandoned.

## Structure
- Shared package jellycore_lsu_pkg: sq_entry_t struct, sq_pos_t (PTR_W+1 typedef), and the commit-code constants.
- One sub-module, sq_age_match: a priority search over a mask rotated relative to head. It returns the youngest match index and the stall flag. It is reused later by the load queue.

## Test plan
- Reset, then dispatch 2'b11 for 4 cycles at SQ_DEPTH=8 → sq_count=8, disp_ready=0; disp_sq_pos wraps from 7 to 8 (index 0, wrap=1).
- Write back pos 0 with addr 0x40/data 0xAA; load at 0x40 with ld_sq_pos=2, pos 1 unresolved → stall=1. Resolve pos 1 with addr 0x80 → hit=1, data=0xAA.
- Two matches at 0x40 (pos0=0x11, pos1=0x22), ld_sq_pos=2 → data=0x22; with ld_sq_pos=1 → data=0x11.
- Commit 2, hold mem_req_ready=0 for 3 cycles → mem_req_valid stays high with stable addr/data; raise ready → two drains, head +2, sq_empty=1.
- Five allocated, commit 2'b01 together with flush → four speculative entries cleared, tail=cmt=1, one store still drains.
- Assert reset mid-drain with mem_req_ready=0 → all outputs return to reset values in the same cycle.

Source files
------------

// File: rtl/jellycore_lsu_pkg.sv
// Shared load/store-unit definitions for the Jellycore store queue and, later, the load queue.
// Types here are sized for the default configuration; parametrised modules derive their own.
package jellycore_lsu_pkg;

  localparam int SQ_DEPTH_DEF = 8;
  localparam int ADDR_W_DEF   = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int ROB_W_DEF    = 6;
  localparam int PTR_W_DEF    = $clog2(SQ_DEPTH_DEF);

  typedef logic [PTR_W_DEF:0] sq_pos_t;

  typedef struct packed {
    logic                  valid;
    logic                  addr_ok;
    logic                  committed;
    logic [ROB_W_DEF-1:0]  rob_idx;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } sq_entry_t;

  // Commit port encodings; 2'b10 is illegal and commits nothing.
  localparam logic [1:0] CMT_NONE = 2'b00;
  localparam logic [1:0] CMT_ONE  = 2'b01;
  localparam logic [1:0] CMT_TWO  = 2'b11;

  function automatic logic [1:0] commit_num(input logic [1:0] code);
    case (code)
      CMT_NONE: commit_num = 2'd0;
      CMT_ONE:  commit_num = 2'd1;
      CMT_TWO:  commit_num = 2'd2;
      default:  commit_num = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    popcount2 = {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/sq_age_match.sv
// Age-ordered priority search: rotates request masks so bit 0 is the oldest slot (base_i),
// limits them to the first span_i slots, and reports the youngest match plus an unresolved-younger flag.
module sq_age_match #(
  parameter  int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] match_i,
  input  logic [DEPTH-1:0] pend_i,
  input  logic [IDX_W-1:0] base_i,
  input  logic [IDX_W:0]   span_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] hit_idx_o,
  output logic             stall_o
);

  logic [DEPTH-1:0] rot_match_s;
  logic [DEPTH-1:0] rot_pend_s;
  logic [IDX_W-1:0] hit_off_s;

  // Rotate into age order and mask off slots outside the older window.
  always_comb begin
    rot_match_s = '0;
    rot_pend_s  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      logic [IDX_W-1:0] src;
      logic             in_win;
      src            = base_i + IDX_W'(k);
      in_win         = (IDX_W+1)'(k) < span_i;
      rot_match_s[k] = in_win & match_i[src];
      rot_pend_s[k]  = in_win & pend_i[src];
    end
  end

  // Youngest match wins, so the last set bit in age order is kept.
  always_comb begin
    hit_o     = 1'b0;
    hit_off_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (rot_match_s[k]) begin
        hit_o     = 1'b1;
        hit_off_s = IDX_W'(k);
      end else begin
        hit_off_s = hit_off_s;
      end
    end
  end

  // Any unresolved slot younger than the match (or anywhere, without a match) blocks forwarding.
  always_comb begin
    stall_o = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      stall_o = stall_o | (rot_pend_s[k] & (~hit_o | (IDX_W'(k) > hit_off_s)));
    end
  end

  assign hit_idx_o = base_i + hit_off_s;

endmodule

// File: rtl/store_queue_p.sv
// Jellycore store queue: two-wide in-order allocation, AGU writeback by position, store-to-load
// forwarding, commit marking, flush of speculative entries and a valid/ready drain to the D-cache.
module store_queue_p
  import jellycore_lsu_pkg::*;
#(
  parameter  int SQ_DEPTH = 8,
  parameter  int ADDR_W   = 32,
  parameter  int DATA_W   = 32,
  parameter  int ROB_W    = 6,
  localparam int PTR_W    = $clog2(SQ_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        disp_valid,
  input  logic [ROB_W-1:0]  disp_rob_idx0,
  input  logic [ROB_W-1:0]  disp_rob_idx1,
  output logic              disp_ready,
  output logic [PTR_W:0]    disp_sq_pos0,
  output logic [PTR_W:0]    disp_sq_pos1,
  input  logic              ex_valid,
  input  logic [PTR_W:0]    ex_sq_pos,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_data,
  input  logic [1:0]        commit_valid,
  input  logic              flush,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [PTR_W:0]    ld_sq_pos,
  output logic              ld_fwd_hit,
  output logic [DATA_W-1:0] ld_fwd_data,
  output logic              ld_fwd_stall,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  input  logic              mem_req_ready,
  output logic [PTR_W:0]    sq_count,
  output logic              sq_empty
);

  typedef logic [PTR_W:0]   pos_t;
  typedef logic [PTR_W-1:0] idx_t;

  typedef struct packed {
    logic              valid;
    logic              addr_ok;
    logic              committed;
    logic [ROB_W-1:0]  rob_idx;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t ent_q [SQ_DEPTH];
  entry_t ent_d [SQ_DEPTH];
  pos_t   head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;

  pos_t        count_s, free_s, ex_off_s, unc_len_s, ld_span_raw_s, ld_span_s;
  idx_t        head_idx_s, cmt_idx_s, cmt1_idx_s, ex_idx_s, pos0_idx_s, pos1_idx_s;
  logic [1:0]  n_cmt_s, n_disp_s;
  logic        disp_fire_s, drain_fire_s, ex_ok_s;
  logic [SQ_DEPTH-1:0] match_s, pend_s;
  logic        am_hit_s, am_stall_s;
  idx_t        am_idx_s;

  assign count_s    = tail_q - head_q;
  assign free_s     = pos_t'(SQ_DEPTH) - count_s;
  assign disp_ready = free_s >= pos_t'(2);
  assign sq_count   = count_s;
  assign sq_empty   = count_s == pos_t'(0);

  assign disp_sq_pos0 = tail_q;
  assign disp_sq_pos1 = tail_q + pos_t'(disp_valid[0]);

  assign head_idx_s = head_q[PTR_W-1:0];
  assign cmt_idx_s  = cmt_q[PTR_W-1:0];
  assign cmt1_idx_s = cmt_idx_s + idx_t'(1);
  assign pos0_idx_s = disp_sq_pos0[PTR_W-1:0];
  assign pos1_idx_s = disp_sq_pos1[PTR_W-1:0];
  assign ex_idx_s   = ex_sq_pos[PTR_W-1:0];

  assign mem_req_valid = ent_q[head_idx_s].valid & ent_q[head_idx_s].committed;
  assign mem_req_addr  = ent_q[head_idx_s].addr;
  assign mem_req_data  = ent_q[head_idx_s].data;
  assign drain_fire_s  = mem_req_valid & mem_req_ready;

  assign n_cmt_s     = commit_num(commit_valid);
  assign disp_fire_s = disp_ready & ~flush & (disp_valid != 2'b00);
  assign n_disp_s    = disp_fire_s ? popcount2(disp_valid) : 2'd0;

  // Writeback must land in the uncommitted window [cmt, tail) on a live entry.
  assign ex_off_s  = ex_sq_pos - cmt_q;
  assign unc_len_s = tail_q - cmt_q;
  assign ex_ok_s   = ex_valid & (ex_off_s < unc_len_s) &
                     ent_q[ex_idx_s].valid & ~ent_q[ex_idx_s].committed;

  // Pointer update; flush rewinds tail to the post-commit cmt and drops dispatch.
  always_comb begin
    cmt_d  = cmt_q + pos_t'(n_cmt_s);
    head_d = drain_fire_s ? head_q + pos_t'(1) : head_q;
    if (flush) begin
      tail_d = cmt_d;
    end else begin
      tail_d = tail_q + pos_t'(n_disp_s);
    end
  end

  // Per-entry update applied as writeback/dispatch, then commit, then flush/drain clearing.
  always_comb begin
    for (int i = 0; i < SQ_DEPTH; i++) begin
      entry_t e;
      idx_t   ii;
      logic   c_hit;
      ii    = idx_t'(i);
      e     = ent_q[i];
      c_hit = ((n_cmt_s != 2'd0) && (cmt_idx_s == ii)) ||
              ((n_cmt_s == 2'd2) && (cmt1_idx_s == ii));
      if (ex_ok_s && (ex_idx_s == ii)) begin
        e.addr    = ex_addr;
        e.data    = ex_data;
        e.addr_ok = 1'b1;
      end else if (disp_fire_s && disp_valid[0] && (pos0_idx_s == ii)) begin
        e = '{valid: 1'b1, addr_ok: 1'b0, committed: 1'b0, rob_idx: disp_rob_idx0,
              addr: '0, data: '0};
      end else if (disp_fire_s && disp_valid[1] && (pos1_idx_s == ii)) begin
        e = '{valid: 1'b1, addr_ok: 1'b0, committed: 1'b0, rob_idx: disp_rob_idx1,
              addr: '0, data: '0};
      end else begin
        e = ent_q[i];
      end
      e.committed = e.committed | c_hit;
      if ((drain_fire_s && (head_idx_s == ii)) || (flush && e.valid && !e.committed)) begin
        ent_d[i] = '0;
      end else begin
        ent_d[i] = e;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
      for (int i = 0; i < SQ_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      cmt_q  <= cmt_d;
      tail_q <= tail_d;
      ent_q  <= ent_d;
    end
  end

  // Forwarding candidates; snapshots already behind head see no older stores.
  always_comb begin
    match_s = '0;
    pend_s  = '0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      match_s[i] = ent_q[i].valid & ent_q[i].addr_ok & (ent_q[i].addr == ld_addr);
      pend_s[i]  = ent_q[i].valid & ~ent_q[i].addr_ok;
    end
  end

  assign ld_span_raw_s = ld_sq_pos - head_q;
  assign ld_span_s     = (ld_span_raw_s > count_s) ? pos_t'(0) : ld_span_raw_s;

  sq_age_match #(
    .DEPTH (SQ_DEPTH)
  ) u_age_match (
    .match_i   (match_s),
    .pend_i    (pend_s),
    .base_i    (head_idx_s),
    .span_i    (ld_span_s),
    .hit_o     (am_hit_s),
    .hit_idx_o (am_idx_s),
    .stall_o   (am_stall_s)
  );

  assign ld_fwd_stall = ld_valid & am_stall_s;
  assign ld_fwd_hit   = ld_valid & am_hit_s & ~am_stall_s;
  assign ld_fwd_data  = ld_fwd_hit ? ent_q[am_idx_s].data : '0;

endmodule

// File: tb/tb_store_queue_p.sv
// Directed scoreboard bench for store_queue_p at SQ_DEPTH=8: expectations are queued as
// stimulus is applied and popped when the corresponding output is sampled.
module tb_store_queue_p;

  localparam int SQ_DEPTH = 8;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int ROB_W    = 6;
  localparam int PTR_W    = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        disp_valid;
  logic [ROB_W-1:0]  disp_rob_idx0, disp_rob_idx1;
  logic              disp_ready;
  logic [PTR_W:0]    disp_sq_pos0, disp_sq_pos1;
  logic              ex_valid;
  logic [PTR_W:0]    ex_sq_pos;
  logic [ADDR_W-1:0] ex_addr;
  logic [DATA_W-1:0] ex_data;
  logic [1:0]        commit_valid;
  logic              flush;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [PTR_W:0]    ld_sq_pos;
  logic              ld_fwd_hit, ld_fwd_stall;
  logic [DATA_W-1:0] ld_fwd_data;
  logic              mem_req_valid, mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_data;
  logic [PTR_W:0]    sq_count;
  logic              sq_empty;

  always #5 clk = ~clk;

  store_queue_p #(
    .SQ_DEPTH (SQ_DEPTH),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .ROB_W    (ROB_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .disp_valid    (disp_valid),
    .disp_rob_idx0 (disp_rob_idx0),
    .disp_rob_idx1 (disp_rob_idx1),
    .disp_ready    (disp_ready),
    .disp_sq_pos0  (disp_sq_pos0),
    .disp_sq_pos1  (disp_sq_pos1),
    .ex_valid      (ex_valid),
    .ex_sq_pos     (ex_sq_pos),
    .ex_addr       (ex_addr),
    .ex_data       (ex_data),
    .commit_valid  (commit_valid),
    .flush         (flush),
    .ld_valid      (ld_valid),
    .ld_addr       (ld_addr),
    .ld_sq_pos     (ld_sq_pos),
    .ld_fwd_hit    (ld_fwd_hit),
    .ld_fwd_data   (ld_fwd_data),
    .ld_fwd_stall  (ld_fwd_stall),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_data  (mem_req_data),
    .mem_req_ready (mem_req_ready),
    .sq_count      (sq_count),
    .sq_empty      (sq_empty)
  );

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_pass  = 0;
  int  n_fail  = 0;
  int  n_total = 0;

  task automatic expect_val(input string tag, input logic [63:0] v);
    sb_q.push_back('{tag, v});
  endtask

  task automatic check(input logic [63:0] obs);
    sb_t e;
    n_total++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_underflow: observed %0h, required a queued expectation", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wb(input logic [PTR_W:0] pos, input logic [31:0] a, input logic [31:0] d);
    ex_valid = 1'b1; ex_sq_pos = pos; ex_addr = a; ex_data = d;
    tick();
    ex_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; disp_valid = 2'b00; disp_rob_idx0 = '0; disp_rob_idx1 = '0;
    ex_valid = 1'b0; ex_sq_pos = '0; ex_addr = '0; ex_data = '0;
    commit_valid = 2'b00; flush = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_sq_pos = '0;
    mem_req_ready = 1'b0;

    // Reset state
    #3;
    expect_val("rst_count", 64'd0); expect_val("rst_empty", 64'd1);
    expect_val("rst_ready", 64'd1); expect_val("rst_memv", 64'd0);
    check(64'(sq_count)); check(64'(sq_empty)); check(64'(disp_ready)); check(64'(mem_req_valid));
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Fill with four dual dispatches; positions walk 0..7 and wrap to 8
    for (int k = 0; k < 4; k++) begin
      disp_valid = 2'b11;
      disp_rob_idx0 = ROB_W'(2 * k);
      disp_rob_idx1 = ROB_W'(2 * k + 1);
      expect_val("disp_pos0", 64'(2 * k)); expect_val("disp_pos1", 64'(2 * k + 1));
      expect_val("disp_ready", 64'd1);
      #1;
      check(64'(disp_sq_pos0)); check(64'(disp_sq_pos1)); check(64'(disp_ready));
      tick();
    end
    disp_valid = 2'b00;
    expect_val("full_count", 64'd8); expect_val("full_ready", 64'd0);
    expect_val("wrap_pos0", 64'd8); expect_val("full_empty", 64'd0);
    #1;
    check(64'(sq_count)); check(64'(disp_ready)); check(64'(disp_sq_pos0)); check(64'(sq_empty));

    // Forwarding: unresolved younger store stalls, resolving it allows the hit
    wb(4'd0, 32'h40, 32'hAA);
    ld_valid = 1'b1; ld_addr = 32'h40; ld_sq_pos = 4'd2;
    expect_val("fwd_stall_unres", 64'd1); expect_val("fwd_hit_unres", 64'd0);
    #1;
    check(64'(ld_fwd_stall)); check(64'(ld_fwd_hit));
    wb(4'd1, 32'h80, 32'hBB);
    expect_val("fwd_hit_res", 64'd1); expect_val("fwd_data_res", 64'hAA);
    expect_val("fwd_stall_res", 64'd0);
    #1;
    check(64'(ld_fwd_hit)); check(64'(ld_fwd_data)); check(64'(ld_fwd_stall));

    // Two matching stores: youngest older one wins, window bounded by ld_sq_pos
    wb(4'd0, 32'h40, 32'h11);
    wb(4'd1, 32'h40, 32'h22);
    ld_sq_pos = 4'd2;
    expect_val("fwd_young_data", 64'h22); expect_val("fwd_young_hit", 64'd1);
    #1;
    check(64'(ld_fwd_data)); check(64'(ld_fwd_hit));
    ld_sq_pos = 4'd1;
    expect_val("fwd_old_data", 64'h11);
    #1;
    check(64'(ld_fwd_data));
    ld_sq_pos = 4'd3;
    expect_val("fwd_pos2_stall", 64'd1); expect_val("fwd_pos2_hit", 64'd0);
    #1;
    check(64'(ld_fwd_stall)); check(64'(ld_fwd_hit));
    ld_addr = 32'h100; ld_sq_pos = 4'd2;
    expect_val("fwd_miss_hit", 64'd0); expect_val("fwd_miss_stall", 64'd0);
    #1;
    check(64'(ld_fwd_hit)); check(64'(ld_fwd_stall));
    ld_valid = 1'b0; ld_addr = 32'h40;
    expect_val("fwd_idle_hit", 64'd0); expect_val("fwd_idle_data", 64'd0);
    #1;
    check(64'(ld_fwd_hit)); check(64'(ld_fwd_data));

    // Commit two with flush: six speculative entries dropped, drain held by ready
    commit_valid = 2'b11; flush = 1'b1;
    tick();
    commit_valid = 2'b00; flush = 1'b0;
    expect_val("cf_count", 64'd2); expect_val("cf_pos0", 64'd2);
    #1;
    check(64'(sq_count)); check(64'(disp_sq_pos0));
    for (int k = 0; k < 3; k++) begin
      mem_req_ready = 1'b0;
      expect_val("hold_memv", 64'd1); expect_val("hold_addr", 64'h40);
      expect_val("hold_data", 64'h11);
      #1;
      check(64'(mem_req_valid)); check(64'(mem_req_addr)); check(64'(mem_req_data));
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    expect_val("drain2_data", 64'h22); expect_val("drain2_memv", 64'd1);
    #1;
    check(64'(mem_req_data)); check(64'(mem_req_valid));
    tick();
    mem_req_ready = 1'b0;
    expect_val("drained_memv", 64'd0); expect_val("drained_empty", 64'd1);
    expect_val("drained_count", 64'd0);
    #1;
    check(64'(mem_req_valid)); check(64'(sq_empty)); check(64'(sq_count));

    // Five allocated at 2..6, then commit one with flush, dispatch and writeback in the same cycle
    disp_valid = 2'b11; tick();
    disp_valid = 2'b11; tick();
    disp_valid = 2'b01; tick();
    disp_valid = 2'b00;
    expect_val("five_count", 64'd5);
    #1;
    check(64'(sq_count));
    wb(4'd2, 32'h200, 32'h55);
    commit_valid = 2'b01; flush = 1'b1; disp_valid = 2'b11;
    ex_valid = 1'b1; ex_sq_pos = 4'd3; ex_addr = 32'h300; ex_data = 32'h99;
    tick();
    commit_valid = 2'b00; flush = 1'b0; disp_valid = 2'b00; ex_valid = 1'b0;
    expect_val("fl_count", 64'd1); expect_val("fl_tail", 64'd3);
    expect_val("fl_memv", 64'd1); expect_val("fl_addr", 64'h200); expect_val("fl_data", 64'h55);
    #1;
    check(64'(sq_count)); check(64'(disp_sq_pos0));
    check(64'(mem_req_valid)); check(64'(mem_req_addr)); check(64'(mem_req_data));
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    expect_val("fl_drained_empty", 64'd1); expect_val("fl_drained_memv", 64'd0);
    #1;
    check(64'(sq_empty)); check(64'(mem_req_valid));

    // Committed store forwards, then asynchronous reset mid-drain
    disp_valid = 2'b01; tick();
    disp_valid = 2'b00;
    wb(4'd3, 32'h400, 32'h77);
    commit_valid = 2'b01; tick();
    commit_valid = 2'b00;
    ld_valid = 1'b1; ld_addr = 32'h400; ld_sq_pos = 4'd4;
    expect_val("pre_rst_memv", 64'd1); expect_val("pre_rst_addr", 64'h400);
    expect_val("cmt_fwd_data", 64'h77);
    #1;
    check(64'(mem_req_valid)); check(64'(mem_req_addr)); check(64'(ld_fwd_data));
    reset = 1'b1;
    expect_val("arst_memv", 64'd0); expect_val("arst_count", 64'd0);
    expect_val("arst_empty", 64'd1); expect_val("arst_ready", 64'd1);
    expect_val("arst_pos0", 64'd0); expect_val("arst_hit", 64'd0);
    expect_val("arst_stall", 64'd0); expect_val("arst_fdata", 64'd0);
    #1;
    check(64'(mem_req_valid)); check(64'(sq_count)); check(64'(sq_empty));
    check(64'(disp_ready)); check(64'(disp_sq_pos0)); check(64'(ld_fwd_hit));
    check(64'(ld_fwd_stall)); check(64'(ld_fwd_data));
    ld_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
